// File: rtl/ttl_74161.sv
// ttl_74161: synchronous presettable binary counter with asynchronous clear,
// modelled on the 74161. Q[2:0] is typically used as the Select of a
// ttl_74151 8:1 mux, and RCO feeds ENT of a higher-order stage when cascading.
module ttl_74161 #(
  parameter int WIDTH      = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic             Clk,
  input  logic             Clear_bar,
  input  logic             Load_bar,
  input  logic             ENP,
  input  logic             ENT,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             rco_d;

  // Next state: load beats count, count needs both enables, otherwise hold.
  // The conditional-operator chain lets an X on a control propagate into Q.
  always_comb begin
    q_d = q_q;
    q_d = !Load_bar ? D : ((ENP & ENT) ? (q_q + ONE) : q_q);
  end

  // Carry out is purely combinational; ENP deliberately plays no part.
  always_comb begin
    rco_d = 1'b0;
    rco_d = ENT & (q_q == ALL_ONES);
  end

  // Counter register with asynchronous active-low clear.
  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign #(DELAY_RISE, DELAY_FALL) Q   = q_q;
  assign #(DELAY_RISE, DELAY_FALL) RCO = rco_d;

endmodule

// File: tb/tb_ttl_74161.sv
// Self-checking bench for ttl_74161: single stage, two-stage cascade and a
// behavioural 8:1 mux driven from Q[2:0].
module tb_ttl_74161;

  logic       clk;
  logic       clear_bar;
  logic       load_bar;
  logic       enp;
  logic       ent;
  logic [3:0] d;
  logic [3:0] q;
  logic       rco;

  logic       c_clr;
  logic       c_load;
  logic       c_enp;
  logic [3:0] c_d_lo;
  logic [3:0] c_d_hi;
  logic [3:0] q_lo;
  logic [3:0] q_hi;
  logic       rco_lo;
  logic       rco_hi;

  int checks;
  int failures;

  logic [3:0] exp_q[$];
  logic       exp_rco[$];
  logic [8:0] exp_cas[$];
  logic       exp_y[$];

  logic [3:0] eq;
  logic       er;
  logic [8:0] ec;
  logic       ey;
  logic [7:0] mux_d;
  logic [7:0] y_seq;

  ttl_74161 #(.WIDTH(4)) dut (
    .Clk(clk), .Clear_bar(clear_bar), .Load_bar(load_bar),
    .ENP(enp), .ENT(ent), .D(d), .Q(q), .RCO(rco)
  );

  ttl_74161 #(.WIDTH(4)) u_lo (
    .Clk(clk), .Clear_bar(c_clr), .Load_bar(c_load),
    .ENP(c_enp), .ENT(1'b1), .D(c_d_lo), .Q(q_lo), .RCO(rco_lo)
  );

  ttl_74161 #(.WIDTH(4)) u_hi (
    .Clk(clk), .Clear_bar(c_clr), .Load_bar(c_load),
    .ENP(c_enp), .ENT(rco_lo), .D(c_d_hi), .Q(q_hi), .RCO(rco_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full clock: rising edge acts, falling edge is where we sample/drive.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_bar = 1'b0; load_bar = 1'b1; enp = 1'b1; ent = 1'b1; d = 4'd0;
    @(negedge clk);
    checks++;
    if (q !== 4'd0 || rco !== 1'b0) begin
      failures++;
      $display("FAIL reset_state q=%0d rco=%b expected q=0 rco=0", q, rco);
    end
    clear_bar = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(4'(i)); exp_rco.push_back(1'b0);
      tick();
      eq = exp_q.pop_front(); er = exp_rco.pop_front();
      checks++;
      if (q !== eq || rco !== er) begin
        failures++;
        $display("FAIL reset_count[%0d] q=%0d rco=%b expected q=%0d rco=%b", i, q, rco, eq, er);
      end
    end
    #2 clear_bar = 1'b0;
    #1;
    checks++;
    if (q !== 4'd0 || rco !== 1'b0) begin
      failures++;
      $display("FAIL reset_async q=%0d rco=%b expected q=0 rco=0", q, rco);
    end
    @(negedge clk);
    load_bar = 1'b0; d = 4'd9;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'd0); exp_rco.push_back(1'b0);
      tick();
      eq = exp_q.pop_front(); er = exp_rco.pop_front();
      checks++;
      if (q !== eq || rco !== er) begin
        failures++;
        $display("FAIL reset_hold[%0d] q=%0d rco=%b expected q=%0d rco=%b", i, q, rco, eq, er);
      end
    end
    load_bar = 1'b1;
    clear_bar = 1'b1;
  endtask

  task automatic test_load_wrap();
    logic [3:0] seq_q [4];
    logic       seq_r [4];
    seq_q = '{4'd13, 4'd14, 4'd15, 4'd0};
    seq_r = '{1'b0, 1'b0, 1'b1, 1'b0};
    load_bar = 1'b0; d = 4'b1101; enp = 1'b0; ent = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(seq_q[i]); exp_rco.push_back(seq_r[i]);
      tick();
      eq = exp_q.pop_front(); er = exp_rco.pop_front();
      checks++;
      if (q !== eq || rco !== er) begin
        failures++;
        $display("FAIL load_wrap[%0d] q=%0d rco=%b expected q=%0d rco=%b", i, q, rco, eq, er);
      end
      load_bar = 1'b1; enp = 1'b1; ent = 1'b1;
    end
  endtask

  task automatic test_enable_gating();
    load_bar = 1'b0; d = 4'hF; enp = 1'b0; ent = 1'b1;
    exp_q.push_back(4'd15); exp_rco.push_back(1'b1);
    tick();
    eq = exp_q.pop_front(); er = exp_rco.pop_front();
    checks++;
    if (q !== eq || rco !== er) begin
      failures++;
      $display("FAIL load_ones q=%0d rco=%b expected q=%0d rco=%b", q, rco, eq, er);
    end
    load_bar = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(4'd15); exp_rco.push_back(1'b1);
      tick();
      eq = exp_q.pop_front(); er = exp_rco.pop_front();
      checks++;
      if (q !== eq || rco !== er) begin
        failures++;
        $display("FAIL gate_enp_low[%0d] q=%0d rco=%b expected q=%0d rco=%b", i, q, rco, eq, er);
      end
    end
    enp = 1'b1; ent = 1'b0;
    #1;
    checks++;
    if (rco !== 1'b0) begin
      failures++;
      $display("FAIL rco_comb_ent rco=%b expected 0", rco);
    end
    exp_q.push_back(4'd15); exp_rco.push_back(1'b0);
    tick();
    eq = exp_q.pop_front(); er = exp_rco.pop_front();
    checks++;
    if (q !== eq || rco !== er) begin
      failures++;
      $display("FAIL gate_ent_low q=%0d rco=%b expected q=%0d rco=%b", q, rco, eq, er);
    end
  endtask

  task automatic test_coincident();
    #2 clear_bar = 1'b0;
    load_bar = 1'b1; enp = 1'b1; ent = 1'b1;
    @(negedge clk);
    exp_q.push_back(4'd0); exp_rco.push_back(1'b0);
    exp_q.push_back(4'd1); exp_rco.push_back(1'b0);
    // Nonblocking so the flop on this edge still sees Clear_bar low.
    @(posedge clk);
    clear_bar <= 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) tick();
      eq = exp_q.pop_front(); er = exp_rco.pop_front();
      checks++;
      if (q !== eq || rco !== er) begin
        failures++;
        $display("FAIL coincident[%0d] q=%0d rco=%b expected q=%0d rco=%b", i, q, rco, eq, er);
      end
    end
  endtask

  task automatic test_cascade();
    logic [7:0] seq_v [4];
    logic       seq_r [4];
    seq_v = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    seq_r = '{1'b0, 1'b1, 1'b0, 1'b0};
    c_clr = 1'b1; c_load = 1'b0; c_enp = 1'b1; c_d_lo = 4'hE; c_d_hi = 4'hF;
    for (int i = 0; i < 4; i++) begin
      exp_cas.push_back({seq_r[i], seq_v[i]});
      tick();
      ec = exp_cas.pop_front();
      checks++;
      if ({rco_hi, q_hi, q_lo} !== ec) begin
        failures++;
        $display("FAIL cascade[%0d] q=%h rco_hi=%b expected q=%h rco_hi=%b",
                 i, {q_hi, q_lo}, rco_hi, ec[7:0], ec[8]);
      end
      c_load = 1'b1;
    end
  endtask

  task automatic test_mux_feed();
    mux_d = 8'b10110010;
    y_seq = 8'b10110010;
    #2 clear_bar = 1'b0;
    load_bar = 1'b1; enp = 1'b1; ent = 1'b1;
    @(negedge clk);
    clear_bar = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_y.push_back(y_seq[i]);
      if (i > 0) tick();
      ey = exp_y.pop_front();
      checks++;
      if (mux_d[q[2:0]] !== ey || q !== 4'(i)) begin
        failures++;
        $display("FAIL mux_feed[%0d] y=%b q=%0d expected y=%b q=%0d", i, mux_d[q[2:0]], q, ey, i);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    c_clr = 1'b0; c_load = 1'b1; c_enp = 1'b0; c_d_lo = 4'd0; c_d_hi = 4'd0;
    test_reset();
    test_load_wrap();
    test_enable_gating();
    test_coincident();
    test_cascade();
    test_mux_feed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ttl_74161.md
Name: ttl_74161

Overview:
Synchronous presettable binary counter with asynchronous clear, WIDTH bits (default 4), modelled on the 74161.
- Primary use: upstream select generator for the 8-input multiplexer. Q[2:0] drives its Select, so a parallel byte on the mux D inputs is scanned out one bit per clock.
- Cascadable through RCO into the ENT of a higher-order stage.

Parameters:
WIDTH, 4, counter width in bits; legal values are 1 and above.
DELAY_RISE, 0, rise delay applied to every output assign.
DELAY_FALL, 0, fall delay applied to every output assign.

Ports:
Clk  input  1  counter clock; all synchronous actions occur on its rising edge.
Clear_bar  input  1  asynchronous active-low reset; Q is forced to 0 while it is low.
Load_bar  input  1  synchronous active-low parallel load.
ENP  input  1  count enable (parallel); does not gate RCO.
ENT  input  1  count enable (trickle); also gates RCO.
D  input  WIDTH  preset value for the parallel load.
Q  output  WIDTH  counter state.
RCO  output  1  ripple carry out.

Interface (already decided): one clock, Clk. Reset Clear_bar is asynchronous and active-low.

Behaviour:
Priority, highest first:
- Clear_bar low:
  - Q = 0 immediately, with no clock edge needed; this holds regardless of Clk, Load_bar, ENP, ENT and D.
  - Reset values: Q = 0; RCO = 0. For WIDTH=1 with ENT high, RCO = 0 because Q = 0.
- Rising Clk with Load_bar low: Q <= D. Load ignores ENP and ENT.
- Rising Clk with Load_bar high, ENP = 1 and ENT = 1: Q <= Q + 1, modulo 2^WIDTH.
- Otherwise: Q holds.

Outputs and timing:
- RCO is combinational: RCO = ENT & (Q == all ones). ENP has no effect on RCO.
- Latency: Q updates on the same rising edge that samples its controls. RCO follows Q and ENT with no added cycle.

Boundary conditions:
- Wrap-around: all ones -> 0 on an enabled edge. RCO then falls with Q.
- Load of all ones with ENT = 1: RCO rises right after that edge.
- Clear asserted mid-count: Q goes to 0 without waiting for Clk. Any concurrent load or count on that edge is discarded.
- Clear deasserted on the same edge as Clk: the edge is ignored and Q stays 0. The first load or count happens on the next rising edge.
- X or Z on Load_bar, ENP or ENT while not in clear: Q goes X. Benches drive known values.
- Cascading: a higher stage takes ENT from the lower stage's RCO and shares Clk and ENP. The chain then counts modulo 2^(n*WIDTH) with no extra latency.
- Delays: both Q and RCO are driven through assign #(DELAY_RISE, DELAY_FALL) from internal registers and logic.

Decomposition:
- No shared package; every constant is derived from WIDTH.
- Single flat module: one always block sensitive to posedge Clk and negedge Clear_bar, plus two delayed assigns.
- No sub-module.
- System-level scanners instantiate this block next to ttl_74151 and connect Q[2:0] to Select.

Test Plan:
1. Reset: count to Q=5, then pull Clear_bar low between edges -> Q=0 immediately and RCO=0. Hold Clear_bar low over 3 edges with Load_bar=0 and D=9 -> Q stays 0.
2. Load and wrap: load D=4'b1101 with ENP=ENT=0 -> Q=13 after one edge. Set ENP=ENT=1 -> Q goes 14, then 15 with RCO=1, then 0 with RCO=0.
3. Enable gating at Q=15:
   - ENP=0, ENT=1 -> Q holds at 15 and RCO=1.
   - ENP=1, ENT=0 -> Q holds and RCO=0.
4. Coincident edge: release Clear_bar on the same rising Clk edge as ENP=ENT=1 -> Q=0 after that edge and Q=1 after the next one.
5. Cascade: two instances with the low stage's RCO driving the high stage's ENT. Preset the pair to 8'hFE and count -> FF, then 00. The high stage's RCO is 1 only while the pair reads FF.
6. Mux feed: Q[2:0] drives ttl_74151 Select, with mux D=8'b10110010 and Enable_bar=0. Count from Clear -> Y sequence 0,1,0,0,1,1,0,1 over 8 cycles, and Y_bar is the complement.
